identificador_compuerta: RTL and testbench

- Sequential identifier that works in the opposite direction to the team's 3-input selectable logic-gate block.
- The gate block maps a 3-bit function code to a logic function. This block drives all 8 input combinations into such a gate, captures the 8-entry truth table, and decodes it back to the function code.
- Used as an on-chip self-test/characterisation engine placed in front of a gate instance.

---
 rtl/identificador_compuerta_if.sv | 40 ++++
 rtl/identificador_compuerta.sv | 137 +++++++++++++
 tb/tb_identificador_compuerta.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/identificador_compuerta_if.sv
// Signal bundle between the gate identifier and its surroundings:
// start/result handshake plus the drive/response wires of the gate under test.
interface identificador_compuerta_if;
    logic       inicio;
    logic       sal_dut;
    logic       ent1;
    logic       ent2;
    logic       ent3;
    logic       act;
    logic       ocupado;
    logic       listo;
    logic [2:0] sel_id;
    logic       valido;

    modport master (
        input  inicio,
        input  sal_dut,
        output ent1,
        output ent2,
        output ent3,
        output act,
        output ocupado,
        output listo,
        output sel_id,
        output valido
    );

    modport slave (
        output inicio,
        output sal_dut,
        input  ent1,
        input  ent2,
        input  ent3,
        input  act,
        input  ocupado,
        input  listo,
        input  sel_id,
        input  valido
    );
endinterface

// File: rtl/identificador_compuerta.sv
// Sweeps all 8 input vectors through a 3-input gate, captures its truth
// table and decodes it back to the gate's 3-bit function code.
module identificador_compuerta #(
    parameter int unsigned ESPERA = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    identificador_compuerta_if.master  bus
);

    localparam logic [3:0] ESPERA_C = 4'(ESPERA);

    typedef enum logic [1:0] {
        REPOSO,
        APLICAR,
        DECODIFICAR,
        FIN
    } estado_t;

    estado_t    state, state_d;
    logic [2:0] idx, idx_d;
    logic [3:0] cnt, cnt_d;
    logic [7:0] tabla, tabla_d;
    logic [2:0] vec, vec_d;
    logic       act_q, act_d;
    logic       ocup_q, ocup_d;
    logic       listo_q, listo_d;
    logic [2:0] sel_q, sel_d;
    logic       valido_q, valido_d;
    logic [2:0] dec_sel;
    logic       dec_ok;

    // Truth table bit i holds the gate response to vector i.
    always_comb begin
        dec_sel = 3'b111;
        dec_ok  = 1'b0;
        unique case (tabla)
            8'h80: begin dec_sel = 3'b001; dec_ok = 1'b1; end
            8'hFE: begin dec_sel = 3'b010; dec_ok = 1'b1; end
            8'h96: begin dec_sel = 3'b011; dec_ok = 1'b1; end
            8'h7F: begin dec_sel = 3'b100; dec_ok = 1'b1; end
            8'h01: begin dec_sel = 3'b101; dec_ok = 1'b1; end
            8'h69: begin dec_sel = 3'b110; dec_ok = 1'b1; end
            8'h00: begin dec_sel = 3'b000; dec_ok = 1'b1; end
            default: begin dec_sel = 3'b111; dec_ok = 1'b0; end
        endcase
    end

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        cnt_d    = cnt;
        tabla_d  = tabla;
        vec_d    = vec;
        act_d    = act_q;
        ocup_d   = ocup_q;
        listo_d  = 1'b0;
        sel_d    = sel_q;
        valido_d = valido_q;
        unique case (state)
            REPOSO: begin
                if (bus.inicio) begin
                    state_d = APLICAR;
                    idx_d   = 3'd0;
                    cnt_d   = 4'd0;
                    vec_d   = 3'd0;
                    act_d   = 1'b1;
                    ocup_d  = 1'b1;
                end
            end
            APLICAR: begin
                if (cnt == ESPERA_C) begin
                    tabla_d[idx] = bus.sal_dut;
                    cnt_d        = 4'd0;
                    if (idx == 3'd7) begin
                        state_d = DECODIFICAR;
                    end else begin
                        idx_d = idx + 3'd1;
                        vec_d = idx + 3'd1;
                    end
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            DECODIFICAR: begin
                state_d  = FIN;
                sel_d    = dec_sel;
                valido_d = dec_ok;
                listo_d  = 1'b1;
                act_d    = 1'b0;
                ocup_d   = 1'b0;
            end
            FIN: begin
                state_d = REPOSO;
            end
            default: begin
                state_d = REPOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= REPOSO;
            idx      <= 3'd0;
            cnt      <= 4'd0;
            tabla    <= 8'h00;
            vec      <= 3'd0;
            act_q    <= 1'b0;
            ocup_q   <= 1'b0;
            listo_q  <= 1'b0;
            sel_q    <= 3'b000;
            valido_q <= 1'b0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            cnt      <= cnt_d;
            tabla    <= tabla_d;
            vec      <= vec_d;
            act_q    <= act_d;
            ocup_q   <= ocup_d;
            listo_q  <= listo_d;
            sel_q    <= sel_d;
            valido_q <= valido_d;
        end
    end

    assign bus.ent1    = vec[2];
    assign bus.ent2    = vec[1];
    assign bus.ent3    = vec[0];
    assign bus.act     = act_q;
    assign bus.ocupado = ocup_q;
    assign bus.listo   = listo_q;
    assign bus.sel_id  = sel_q;
    assign bus.valido  = valido_q;

endmodule

// File: tb/tb_identificador_compuerta.sv
// Directed and randomized bench for the gate identifier, with one
// instance at ESPERA=1 and one at ESPERA=0.
module tb_identificador_compuerta;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    identificador_compuerta_if b1 ();
    identificador_compuerta_if b0 ();

    identificador_compuerta #(.ESPERA(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.master)
    );

    identificador_compuerta #(.ESPERA(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0.master)
    );

    function automatic logic gate_fn(input logic [2:0] s, input logic [2:0] v);
        case (s)
            3'b001: return &v;
            3'b010: return |v;
            3'b011: return ^v;
            3'b100: return ~&v;
            3'b101: return ~|v;
            3'b110: return ~^v;
            default: return 1'b0;
        endcase
    endfunction

    // Table seen by the identifier; dly models a gate whose output lags
    // its inputs by one clock while vectors are held only one cycle.
    function automatic logic [7:0] table_of(input logic [2:0] s, input logic dly);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            if (dly) t[i] = (i == 0) ? 1'b0 : gate_fn(s, 3'(i - 1));
            else     t[i] = gate_fn(s, 3'(i));
        end
        return t;
    endfunction

    // {valido, sel_id} expected for a captured table.
    function automatic logic [3:0] ref_id(input logic [7:0] t);
        logic [3:0] r;
        r = 4'b0111;
        if (t == 8'h00) r = 4'b1000;
        for (int s = 1; s <= 6; s++) begin
            if (table_of(3'(s), 1'b0) == t) r = {1'b1, 3'(s)};
        end
        return r;
    endfunction

    logic [2:0] sel1 = 3'd0;
    logic [2:0] sel0 = 3'd0;
    logic       pat_mode1 = 1'b0;
    logic [7:0] pat1 = 8'h00;
    logic       dly1 = 1'b0;
    logic       dly0 = 1'b0;
    logic       g1_q;
    logic       g0_q;
    logic [3:0] last1 = 4'b0000;
    wire  [2:0] v1 = {b1.ent1, b1.ent2, b1.ent3};
    wire  [2:0] v0 = {b0.ent1, b0.ent2, b0.ent3};

    always_ff @(posedge clk) begin
        g1_q <= b1.act & gate_fn(sel1, v1);
        g0_q <= b0.act & gate_fn(sel0, v0);
    end

    assign b1.sal_dut = pat_mode1 ? pat1[v1] :
                        dly1 ? g1_q : (b1.act & gate_fn(sel1, v1));
    assign b0.sal_dut = dly0 ? g0_q : (b0.act & gate_fn(sel0, v0));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run1(input string tag, input logic [3:0] expd);
        int n;
        @(negedge clk);
        b1.inicio = 1'b1;
        @(posedge clk);
        #1;
        b1.inicio = 1'b0;
        chk({tag, "_start_busy"}, {6'd0, b1.act, b1.ocupado}, 8'h03);
        chk({tag, "_start_vec"}, {5'd0, v1}, 8'h00);
        n = 0;
        while (!b1.listo && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n < 16 && !b1.listo) chk({tag, "_vec"}, {5'd0, v1}, 8'(n / 2));
            if (n == 5) b1.inicio = 1'b1;
            if (n == 6) b1.inicio = 1'b0;
            if (n == 8) chk({tag, "_hold_prev"}, {4'd0, b1.valido, b1.sel_id}, {4'd0, last1});
        end
        chk({tag, "_latency"}, 8'(n), 8'd17);
        chk({tag, "_id"}, {4'd0, b1.valido, b1.sel_id}, {4'd0, expd});
        chk({tag, "_done_idle"}, {6'd0, b1.act, b1.ocupado}, 8'h00);
        last1 = expd;
        b1.inicio = 1'b1;
        @(posedge clk);
        #1;
        b1.inicio = 1'b0;
        chk({tag, "_listo_pulse"}, {7'd0, b1.listo}, 8'h00);
        chk({tag, "_no_queue_a"}, {7'd0, b1.act}, 8'h00);
        @(posedge clk);
        #1;
        chk({tag, "_no_queue_b"}, {6'd0, b1.act, b1.ocupado}, 8'h00);
        chk({tag, "_last_vec"}, {5'd0, v1}, 8'h07);
    endtask

    task automatic run0(input string tag, input logic [3:0] expd);
        int n;
        @(negedge clk);
        b0.inicio = 1'b1;
        @(posedge clk);
        #1;
        b0.inicio = 1'b0;
        n = 0;
        while (!b0.listo && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, 8'(n), 8'd9);
        chk({tag, "_id"}, {4'd0, b0.valido, b0.sel_id}, {4'd0, expd});
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int n;
        int first;
        int second;
        int cnt_listo;
        b1.inicio = 1'b0;
        b0.inicio = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out1", {b1.ent1, b1.ent2, b1.ent3, b1.act, b1.ocupado, b1.listo, b1.valido, 1'b0}, 8'h00);
        chk("rst_sel1", {5'd0, b1.sel_id}, 8'h00);
        chk("rst_out0", {b0.act, b0.ocupado, b0.listo, b0.valido, 1'b0, b0.sel_id}, 8'h00);
        rst_n = 1'b1;

        for (int s = 0; s < 8; s++) begin
            sel1 = 3'(s);
            run1($sformatf("gate%0d", s), ref_id(table_of(3'(s), 1'b0)));
        end

        sel1 = 3'b011;
        dly1 = 1'b1;
        run1("dly_e1", ref_id(table_of(3'b011, 1'b0)));
        dly1 = 1'b0;

        pat_mode1 = 1'b1;
        pat1 = 8'hA5;
        run1("pat_a5", ref_id(8'hA5));
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 1) == 1)
                pat1 = table_of(3'($urandom_range(0, 7)), 1'b0);
            else
                pat1 = 8'($urandom);
            run1($sformatf("rnd%0d", k), ref_id(pat1));
        end
        pat_mode1 = 1'b0;

        sel0 = 3'b011;
        run0("e0_comb", ref_id(table_of(3'b011, 1'b0)));
        dly0 = 1'b1;
        run0("e0_dly", ref_id(table_of(3'b011, 1'b1)));
        dly0 = 1'b0;

        sel1 = 3'b110;
        @(negedge clk);
        b1.inicio = 1'b1;
        @(posedge clk);
        #1;
        b1.inicio = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_out", {b1.ent1, b1.ent2, b1.ent3, b1.act, b1.ocupado, b1.listo, b1.valido, 1'b0}, 8'h00);
        chk("midrst_sel", {5'd0, b1.sel_id}, 8'h00);
        rst_n = 1'b1;
        last1 = 4'b0000;
        cnt_listo = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (b1.listo) cnt_listo++;
        end
        chk("midrst_no_listo", 8'(cnt_listo), 8'd0);
        run1("after_rst", ref_id(table_of(3'b110, 1'b0)));

        sel1 = 3'b101;
        @(negedge clk);
        b1.inicio = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        first = -1;
        second = -1;
        while (second < 0 && n < 80) begin
            @(posedge clk);
            #1;
            n++;
            if (b1.listo) begin
                if (first < 0) first = n;
                else second = n;
            end
        end
        b1.inicio = 1'b0;
        chk("b2b_first", 8'(first), 8'd17);
        chk("b2b_second", 8'(second), 8'd36);
        chk("b2b_id", {4'd0, b1.valido, b1.sel_id}, {4'd0, ref_id(table_of(3'b101, 1'b0))});
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
